// File: rtl/branch_predictor_configurable_pkg.sv
// Shared encodings for the fetch-stage next-PC predictor: direction-mode
// selectors, 2-bit saturating counter states and the counter update helper.
package branch_predictor_configurable_pkg;

  localparam logic [1:0] BP_MODE_NT      = 2'd0;
  localparam logic [1:0] BP_MODE_T       = 2'd1;
  localparam logic [1:0] BP_MODE_BIMODAL = 2'd2;
  localparam logic [1:0] BP_MODE_GSHARE  = 2'd3;

  localparam logic [1:0] SAT_SNT  = 2'b00;
  localparam logic [1:0] SAT_WNT  = 2'b01;
  localparam logic [1:0] SAT_WT   = 2'b10;
  localparam logic [1:0] SAT_ST   = 2'b11;
  localparam logic [1:0] SAT_INIT = SAT_WNT;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (cnt == SAT_ST) res = SAT_ST;
      else               res = cnt + 2'b01;
    end else begin
      if (cnt == SAT_SNT) res = SAT_SNT;
      else                res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_configurable_pht.sv
// Pattern history table: 2**IDX_W two-bit saturating counters with one
// combinational direction read and one clocked training write.
module branch_predictor_configurable_pht
  import branch_predictor_configurable_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_dir,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0] cnt_r [DEPTH];

  assign rd_dir = cnt_r[rd_idx][1];

  // Reset every counter to weakly not-taken, otherwise train the resolved entry
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) cnt_r[k] <= SAT_INIT;
    end else if (wr_en) begin
      cnt_r[wr_idx] <= sat_next(cnt_r[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predictor_configurable.sv
// Fetch-stage next-PC predictor: direct-mapped BTB plus selectable direction
// predictor, trained from the branch-resolve stage, with branch/mispredict counters.
module branch_predictor_configurable
  import branch_predictor_configurable_pkg::*;
#(
  parameter int                WORD_W   = 16,
  parameter int                IDX_W    = 8,
  parameter int                HIST_W   = 8,
  parameter int                MODE     = 3,
  parameter logic [WORD_W-1:0] PC_LIMIT = WORD_W'(16'hc6),
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pred_next_pc,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_pht_idx,
  input  logic              rs_valid,
  input  logic [WORD_W-1:0] rs_pc,
  input  logic              rs_is_cond,
  input  logic              rs_taken,
  input  logic [WORD_W-1:0] rs_target,
  input  logic [IDX_W-1:0]  rs_pht_idx,
  input  logic              rs_mispredict,
  input  logic [WORD_W-1:0] rs_next_pc,
  output logic [CNT_W-1:0]  perf_branches,
  output logic [CNT_W-1:0]  perf_mispredicts
);
  localparam int         DEPTH    = 2 ** IDX_W;
  localparam int         TAG_W    = WORD_W - IDX_W;
  localparam logic [1:0] MODE_SEL = 2'(MODE);

  logic              valid_r  [DEPTH];
  logic [TAG_W-1:0]  tag_r    [DEPTH];
  logic [WORD_W-1:0] target_r [DEPTH];
  logic              uncond_r [DEPTH];
  logic [HIST_W-1:0] ghr_r;
  logic [CNT_W-1:0]  branches_r;
  logic [CNT_W-1:0]  mispredicts_r;

  logic [IDX_W-1:0]  btb_idx_s;
  logic [IDX_W-1:0]  gshare_idx_s;
  logic [IDX_W-1:0]  pht_idx_s;
  logic [IDX_W-1:0]  rs_btb_idx_s;
  logic [WORD_W-1:0] ft_s;
  logic              hit_s;
  logic              pht_dir_s;
  logic              taken_s;
  logic              btb_wr_s;
  logic              pht_wr_s;
  logic              ghr_wr_s;

  assign btb_idx_s    = pc[IDX_W-1:0];
  assign rs_btb_idx_s = rs_pc[IDX_W-1:0];
  assign gshare_idx_s = btb_idx_s ^ IDX_W'(ghr_r);
  assign pht_idx_s    = (MODE_SEL == BP_MODE_GSHARE) ? gshare_idx_s : btb_idx_s;
  assign hit_s        = valid_r[btb_idx_s] && (tag_r[btb_idx_s] == pc[WORD_W-1:IDX_W]);

  // Table writes see only resolves outside reset; not-taken never allocates a BTB entry
  assign btb_wr_s = reset_n & rs_valid & rs_taken & (MODE_SEL != BP_MODE_NT);
  assign pht_wr_s = reset_n & rs_valid & rs_is_cond &
                    ((MODE_SEL == BP_MODE_BIMODAL) | (MODE_SEL == BP_MODE_GSHARE));
  assign ghr_wr_s = reset_n & rs_valid & rs_is_cond & (MODE_SEL == BP_MODE_GSHARE);

  branch_predictor_configurable_pht #(.IDX_W(IDX_W)) u_pht (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (pht_idx_s),
    .rd_dir   (pht_dir_s),
    .wr_en    (pht_wr_s),
    .wr_idx   (rs_pht_idx),
    .wr_taken (rs_taken)
  );

  // Fall-through address and direction decision for the current fetch PC
  always_comb begin
    ft_s    = pc + WORD_W'(1'b1);
    taken_s = 1'b0;
    if (pc >= PC_LIMIT) ft_s = pc;
    else                ft_s = pc + WORD_W'(1'b1);
    case (MODE_SEL)
      BP_MODE_NT:      taken_s = 1'b0;
      BP_MODE_T:       taken_s = hit_s;
      BP_MODE_BIMODAL: taken_s = hit_s & (uncond_r[btb_idx_s] | pht_dir_s);
      BP_MODE_GSHARE:  taken_s = hit_s & (uncond_r[btb_idx_s] | pht_dir_s);
      default:         taken_s = 1'b0;
    endcase
  end

  // Redirect from the resolve stage outranks any prediction
  always_comb begin
    pred_next_pc = ft_s;
    if (rs_mispredict)  pred_next_pc = rs_next_pc;
    else if (taken_s)   pred_next_pc = target_r[btb_idx_s];
    else                pred_next_pc = ft_s;
  end

  assign pred_taken       = taken_s;
  assign pred_pht_idx     = pht_idx_s;
  assign perf_branches    = branches_r;
  assign perf_mispredicts = mispredicts_r;

  // Valid bits are the only BTB state that needs clearing
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) valid_r[k] <= 1'b0;
    end else if (btb_wr_s) begin
      valid_r[rs_btb_idx_s] <= 1'b1;
    end
  end

  // BTB payload, always qualified by valid on read
  always_ff @(posedge clk) begin
    if (btb_wr_s) begin
      tag_r[rs_btb_idx_s]    <= rs_pc[WORD_W-1:IDX_W];
      target_r[rs_btb_idx_s] <= rs_target;
      uncond_r[rs_btb_idx_s] <= ~rs_is_cond;
    end
  end

  // Global history shifts in each resolved conditional outcome
  always_ff @(posedge clk) begin
    if (!reset_n)      ghr_r <= {HIST_W{1'b0}};
    else if (ghr_wr_s) ghr_r <= HIST_W'({ghr_r, rs_taken});
  end

  // Performance counters wrap naturally at 2**CNT_W
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      branches_r    <= {CNT_W{1'b0}};
      mispredicts_r <= {CNT_W{1'b0}};
    end else if (rs_valid) begin
      branches_r <= branches_r + CNT_W'(1'b1);
      if (rs_mispredict) mispredicts_r <= mispredicts_r + CNT_W'(1'b1);
    end
  end

endmodule
